// File: rtl/sd_number_parser_if.sv
// rtl/sd_number_parser_if.sv - byte-in / word-out handshake bundle for sd_number_parser
interface sd_number_parser_if #(
    parameter int W = 16
) ();
    logic         in_valid;
    logic [7:0]   in_byte;
    logic         in_done;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, in_byte, in_done, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_byte, in_done, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/sd_number_parser.sv
// rtl/sd_number_parser.sv - ASCII decimal integer tokenizer with saturating accumulator and output FIFO
// Optional macro SMVM_PARSER_COMMENT_EN: '#' starts a comment that runs to LF.
module sd_number_parser #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    sd_number_parser_if.slave      bus,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            value_count,
    output logic                   err_overflow,
    output logic                   err_format,
    output logic                   err_saturate
);
    localparam int AW   = $clog2(DEPTH);
    localparam int ACCW = W + 4;
    localparam logic [ACCW-1:0] LIM_POS = {5'b0, {(W-1){1'b1}}};
    localparam logic [ACCW-1:0] LIM_NEG = {4'b0, 1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SIGN,
        S_DIGITS,
        S_DISCARD
`ifdef SMVM_PARSER_COMMENT_EN
        , S_COMMENT
`endif
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ACCW-1:0] r_acc;
    logic [ACCW-1:0] w_acc_nxt;
    logic [ACCW-1:0] w_acc_mac;
    logic [ACCW-1:0] w_digit;
    logic [ACCW-1:0] w_lim;
    logic            r_neg;
    logic            w_neg_nxt;
    logic            w_commit;
    logic            w_set_fmt;
    logic            w_set_sat;
    logic [W-1:0]    w_commit_val;
    logic            w_is_digit;
    logic            w_is_minus;
    logic            w_is_sep;
`ifdef SMVM_PARSER_COMMENT_EN
    logic            w_is_hash;
`endif

    logic [W-1:0]    r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic [15:0]     r_vcnt;
    logic            r_err_ovf;
    logic            r_err_fmt;
    logic            r_err_sat;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    assign w_is_digit = (bus.in_byte >= 8'h30) && (bus.in_byte <= 8'h39);
    assign w_is_minus = (bus.in_byte == 8'h2D);
    assign w_is_sep   = (bus.in_byte == 8'h20) || (bus.in_byte == 8'h09) ||
                        (bus.in_byte == 8'h0A) || (bus.in_byte == 8'h0D) ||
                        (bus.in_byte == 8'h2C);
`ifdef SMVM_PARSER_COMMENT_EN
    assign w_is_hash  = (bus.in_byte == 8'h23);
`endif

    // acc never exceeds 2^(W-1), so acc*10+9 always fits in W+4 bits
    assign w_digit   = {{(ACCW-4){1'b0}}, bus.in_byte[3:0]};
    assign w_acc_mac = (r_acc << 3) + (r_acc << 1) + w_digit;
    assign w_lim     = r_neg ? LIM_NEG : LIM_POS;

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_neg_nxt    = r_neg;
        w_commit     = 1'b0;
        w_set_fmt    = 1'b0;
        w_set_sat    = 1'b0;
        w_commit_val = '0;
        if (bus.in_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_digit) begin
                        w_acc_nxt   = w_digit;
                        w_neg_nxt   = 1'b0;
                        w_state_nxt = S_DIGITS;
                    end else if (w_is_minus) begin
                        w_neg_nxt   = 1'b1;
                        w_state_nxt = S_SIGN;
                    end else if (w_is_sep) begin
                        w_state_nxt = S_IDLE;
`ifdef SMVM_PARSER_COMMENT_EN
                    end else if (w_is_hash) begin
                        w_state_nxt = S_COMMENT;
`endif
                    end else begin
                        w_set_fmt   = 1'b1;
                        w_state_nxt = S_DISCARD;
                    end
                end
                S_SIGN: begin
                    if (w_is_digit) begin
                        w_acc_nxt   = w_digit;
                        w_state_nxt = S_DIGITS;
                    end else if (w_is_sep) begin
                        w_set_fmt   = 1'b1;
                        w_state_nxt = S_IDLE;
`ifdef SMVM_PARSER_COMMENT_EN
                    end else if (w_is_hash) begin
                        w_set_fmt   = 1'b1;
                        w_state_nxt = S_COMMENT;
`endif
                    end else begin
                        w_set_fmt   = 1'b1;
                        w_state_nxt = S_DISCARD;
                    end
                end
                S_DIGITS: begin
                    if (w_is_digit) begin
                        if (w_acc_mac > w_lim) begin
                            w_acc_nxt = w_lim;
                            w_set_sat = 1'b1;
                        end else begin
                            w_acc_nxt = w_acc_mac;
                        end
                    end else if (w_is_sep) begin
                        w_commit    = 1'b1;
                        w_state_nxt = S_IDLE;
`ifdef SMVM_PARSER_COMMENT_EN
                    end else if (w_is_hash) begin
                        w_commit    = 1'b1;
                        w_state_nxt = S_COMMENT;
`endif
                    end else begin
                        w_set_fmt   = 1'b1;
                        w_state_nxt = S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (w_is_sep) w_state_nxt = S_IDLE;
                end
`ifdef SMVM_PARSER_COMMENT_EN
                S_COMMENT: begin
                    if (bus.in_byte == 8'h0A) w_state_nxt = S_IDLE;
                end
`endif
                default: w_state_nxt = S_IDLE;
            endcase
        end
        // flush sees the state left by this cycle's byte, so a final digit is kept
        if (bus.in_done) begin
            if (w_state_nxt == S_DIGITS) w_commit  = 1'b1;
            if (w_state_nxt == S_SIGN)   w_set_fmt = 1'b1;
            w_state_nxt = S_IDLE;
        end
        w_commit_val = w_neg_nxt ? (~w_acc_nxt[W-1:0] + 1'b1) : w_acc_nxt[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_neg   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_neg   <= w_neg_nxt;
        end
    end

    // a pop in the same cycle frees the slot a full-FIFO push needs
    assign w_full = (r_count == (AW+1)'(DEPTH));
    assign w_pop  = (r_count != '0) && bus.out_ready;
    assign w_push = w_commit && (!w_full || w_pop);
    assign w_drop = w_commit && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_commit_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_vcnt    <= '0;
            r_err_ovf <= 1'b0;
            r_err_fmt <= 1'b0;
            r_err_sat <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
                r_vcnt <= r_vcnt + 16'd1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop)    r_err_ovf <= 1'b1;
            if (w_set_fmt) r_err_fmt <= 1'b1;
            if (w_set_sat) r_err_sat <= 1'b1;
        end
    end

    assign bus.out_valid = (r_count != '0);
    assign bus.out_data  = (r_count != '0) ? r_mem[r_rptr] : '0;
    assign fifo_count    = r_count;
    assign value_count   = r_vcnt;
    assign err_overflow  = r_err_ovf;
    assign err_format    = r_err_fmt;
    assign err_saturate  = r_err_sat;
endmodule
